// File: rtl/motor_array.sv
// motor_array: N independent door-motor channels with edge-triggered start,
// stop mid-travel, dead-time reversal and travel time-out fault.
// Optional obstruction reversal is compiled in with `define MOTOR_OBSTRUCT_EN.
module motor_array #(
    parameter int N          = 1,
    parameter int TIMER_W    = 16,
    parameter int TRAVEL_MAX = 1000,
    parameter int DEAD_W     = 4,
    parameter int DEAD_CYC   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] activate,
    input  logic [N-1:0] up_limit,
    input  logic [N-1:0] dn_limit,
`ifdef MOTOR_OBSTRUCT_EN
    input  logic [N-1:0] obstruct,
`endif
    input  logic [N-1:0] fault_clr,
    output logic [N-1:0] motor_up,
    output logic [N-1:0] motor_dn,
    output logic [N-1:0] busy,
    output logic [N-1:0] fault
);

    typedef enum logic [2:0] {
        REST   = 3'd0,
        MOV_DN = 3'd1,
        MOV_UP = 3'd2,
        PAUSE  = 3'd3,
        FAULT  = 3'd4
    } state_t;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_t;

    localparam logic [TIMER_W-1:0] TRAVEL_LIM = TIMER_W'(TRAVEL_MAX);
    localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYC - 1);

    for (genvar g = 0; g < N; g++) begin : g_ch
        state_t             state, state_nxt;
        dir_t               last_dir, last_dir_nxt;
        dir_t               next_dir, next_dir_nxt;
        dir_t               rev_dir;
        logic               moved, moved_nxt;
        logic               act_q, act_edge, both_lim;
        logic [TIMER_W-1:0] timer, timer_nxt, timer_inc;
        logic [DEAD_W-1:0]  dead, dead_nxt;
        logic               up_q, dn_q, busy_q, fault_q;

        assign act_edge  = activate[g] & ~act_q;
        assign both_lim  = up_limit[g] & dn_limit[g];
        assign rev_dir   = (last_dir == DIR_DN) ? DIR_UP : DIR_DN;
        assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

        // Next-state and register-update logic for one channel.
        // 'moved' separates the first start after reset (direct, no pause)
        // from a restart after the motor has actually been driven.
        // The time-out compares the incremented count so the motor runs
        // exactly TRAVEL_MAX cycles including the entry cycle.
        always_comb begin
            state_nxt    = state;
            last_dir_nxt = last_dir;
            next_dir_nxt = next_dir;
            moved_nxt    = moved;
            timer_nxt    = timer;
            dead_nxt     = dead;
            case (state)
                REST: begin
                    if (act_edge) begin
                        if (both_lim)          state_nxt = FAULT;
                        else if (up_limit[g])  state_nxt = MOV_DN;
                        else if (dn_limit[g])  state_nxt = MOV_UP;
                        else if (moved) begin
                            state_nxt    = PAUSE;
                            next_dir_nxt = rev_dir;
                        end else begin
                            state_nxt = (rev_dir == DIR_UP) ? MOV_UP : MOV_DN;
                        end
                    end
                end
                MOV_DN: begin
                    timer_nxt = timer_inc;
                    if (both_lim) begin
                        state_nxt = FAULT;
                    end else if (dn_limit[g]) begin
                        state_nxt    = REST;
                        last_dir_nxt = DIR_DN;
`ifdef MOTOR_OBSTRUCT_EN
                    end else if (obstruct[g]) begin
                        state_nxt    = PAUSE;
                        next_dir_nxt = DIR_UP;
                        last_dir_nxt = DIR_DN;
`endif
                    end else if (act_edge) begin
                        state_nxt    = REST;
                        last_dir_nxt = DIR_DN;
                    end else if (timer_inc == TRAVEL_LIM) begin
                        state_nxt = FAULT;
                    end
                end
                MOV_UP: begin
                    timer_nxt = timer_inc;
                    if (both_lim) begin
                        state_nxt = FAULT;
                    end else if (up_limit[g]) begin
                        state_nxt    = REST;
                        last_dir_nxt = DIR_UP;
                    end else if (act_edge) begin
                        state_nxt    = REST;
                        last_dir_nxt = DIR_UP;
                    end else if (timer_inc == TRAVEL_LIM) begin
                        state_nxt = FAULT;
                    end
                end
                PAUSE: begin
                    dead_nxt = dead + 1'b1;
                    if (act_edge) begin
                        state_nxt    = REST;
                        last_dir_nxt = (next_dir == DIR_UP) ? DIR_DN : DIR_UP;
                    end else if (dead == DEAD_LAST) begin
                        state_nxt = (next_dir == DIR_UP) ? MOV_UP : MOV_DN;
                    end
                end
                FAULT: begin
                    if (fault_clr[g]) state_nxt = REST;
                end
                default: state_nxt = REST;
            endcase

            if (state_nxt != state) begin
                if (state_nxt == MOV_UP || state_nxt == MOV_DN) begin
                    timer_nxt = '0;
                    moved_nxt = 1'b1;
                end
                if (state_nxt == PAUSE) dead_nxt = '0;
            end
        end

        // State, counters and outputs decoded from the next state.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= REST;
                last_dir <= DIR_DN;
                next_dir <= DIR_DN;
                moved    <= 1'b0;
                act_q    <= 1'b0;
                timer    <= '0;
                dead     <= '0;
                up_q     <= 1'b0;
                dn_q     <= 1'b0;
                busy_q   <= 1'b0;
                fault_q  <= 1'b0;
            end else begin
                state    <= state_nxt;
                last_dir <= last_dir_nxt;
                next_dir <= next_dir_nxt;
                moved    <= moved_nxt;
                act_q    <= activate[g];
                timer    <= timer_nxt;
                dead     <= dead_nxt;
                up_q     <= (state_nxt == MOV_UP);
                dn_q     <= (state_nxt == MOV_DN);
                busy_q   <= (state_nxt == MOV_UP) || (state_nxt == MOV_DN) ||
                            (state_nxt == PAUSE);
                fault_q  <= (state_nxt == FAULT);
            end
        end

        assign motor_up[g] = up_q;
        assign motor_dn[g] = dn_q;
        assign busy[g]     = busy_q;
        assign fault[g]    = fault_q;
    end

endmodule

// File: tb/tb_motor_array.sv
// Testbench for motor_array: N=2, TRAVEL_MAX=20, DEAD_CYC=3.
// Define MOTOR_OBSTRUCT_EN to also exercise obstruction reversal.
module tb_motor_array;

    localparam int TMAX = 20;
    localparam int DEAD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] activate, up_limit, dn_limit, fault_clr;
    logic [1:0] motor_up, motor_dn, busy, fault;
`ifdef MOTOR_OBSTRUCT_EN
    logic [1:0] obstruct;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    motor_array #(
        .N(2), .TIMER_W(16), .TRAVEL_MAX(TMAX), .DEAD_W(4), .DEAD_CYC(DEAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .activate(activate),
        .up_limit(up_limit),
        .dn_limit(dn_limit),
`ifdef MOTOR_OBSTRUCT_EN
        .obstruct(obstruct),
`endif
        .fault_clr(fault_clr),
        .motor_up(motor_up),
        .motor_dn(motor_dn),
        .busy(busy),
        .fault(fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Door model: direction of travel (-1 down, 0 stopped, +1 up),
    // remaining pause cycles with pending direction, elapsed travel.
    int m_dir[2], m_pause[2], m_pend[2], m_travel[2], m_lastd[2];
    bit m_flt[2], m_actp[2], m_moved[2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_dir[c] = 0; m_pause[c] = 0; m_pend[c] = 0; m_travel[c] = 0;
            m_lastd[c] = -1; m_flt[c] = 0; m_actp[c] = 0; m_moved[c] = 0;
        end
    endtask

    task automatic model_start(input int c, input int d);
        m_dir[c] = d; m_travel[c] = 0; m_moved[c] = 1;
    endtask

    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            bit a, u, d, o, rise;
            a = activate[c]; u = up_limit[c]; d = dn_limit[c]; o = 1'b0;
`ifdef MOTOR_OBSTRUCT_EN
            o = obstruct[c];
`endif
            rise = a && !m_actp[c];
            m_actp[c] = a;
            if (m_flt[c]) begin
                if (fault_clr[c]) m_flt[c] = 0;
            end else if (m_pause[c] > 0) begin
                if (rise) begin
                    m_pause[c] = 0;
                    m_lastd[c] = -m_pend[c];
                end else begin
                    m_pause[c]--;
                    if (m_pause[c] == 0) model_start(c, m_pend[c]);
                end
            end else if (m_dir[c] == 0) begin
                if (rise) begin
                    if (u && d)          m_flt[c] = 1;
                    else if (u)          model_start(c, -1);
                    else if (d)          model_start(c, 1);
                    else if (m_moved[c]) begin m_pause[c] = DEAD; m_pend[c] = -m_lastd[c]; end
                    else                 model_start(c, -m_lastd[c]);
                end
            end else begin
                m_travel[c]++;
                if (u && d) begin
                    m_flt[c] = 1; m_dir[c] = 0;
                end else if ((m_dir[c] < 0 && d) || (m_dir[c] > 0 && u)) begin
                    m_lastd[c] = m_dir[c]; m_dir[c] = 0;
                end else if (m_dir[c] < 0 && o) begin
                    m_lastd[c] = -1; m_dir[c] = 0; m_pause[c] = DEAD; m_pend[c] = 1;
                end else if (rise) begin
                    m_lastd[c] = m_dir[c]; m_dir[c] = 0;
                end else if (m_travel[c] >= TMAX) begin
                    m_flt[c] = 1; m_dir[c] = 0;
                end
            end
        end
    endtask

    // Model advances on each clock edge, or resets immediately with rst.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial begin
        logic [1:0] e_up, e_dn, e_busy, e_flt;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                e_up[c]   = (m_dir[c] > 0);
                e_dn[c]   = (m_dir[c] < 0);
                e_busy[c] = (m_dir[c] != 0) || (m_pause[c] > 0);
                e_flt[c]  = m_flt[c];
            end
            check("model_motor_up", 32'(motor_up), 32'(e_up));
            check("model_motor_dn", 32'(motor_dn), 32'(e_dn));
            check("model_busy",     32'(busy),     32'(e_busy));
            check("model_fault",    32'(fault),    32'(e_flt));
            check("up_dn_overlap",  32'(motor_up & motor_dn), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int gap, cnt, hi;
        activate = '0; up_limit = '0; dn_limit = '0; fault_clr = '0;
`ifdef MOTOR_OBSTRUCT_EN
        obstruct = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_motor_up", 32'(motor_up), 0);
        check("rst_motor_dn", 32'(motor_dn), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_fault",    32'(fault), 0);
        rst = 1'b0;

        // Open-close cycle on ch0
        up_limit = 2'b01;
        @(negedge clk); activate = 2'b01;
        @(negedge clk); activate = '0; up_limit = '0;
        check("close_start_dn", 32'(motor_dn), 32'b01);
        check("close_start_up", 32'(motor_up), 0);
        repeat (4) @(negedge clk); dn_limit = 2'b01;
        @(negedge clk);
        check("closed_dn",   32'(motor_dn), 0);
        check("closed_busy", 32'(busy), 0);
        activate = 2'b01;
        @(negedge clk); activate = '0; dn_limit = '0;
        check("open_start_up", 32'(motor_up), 32'b01);
        repeat (6) @(negedge clk); up_limit = 2'b01;
        @(negedge clk);
        check("opened_up", 32'(motor_up), 0);

        // Stop mid-travel, then reverse through the dead time
        activate = 2'b01;
        @(negedge clk); activate = '0; up_limit = '0;
        repeat (3) @(negedge clk); activate = 2'b01;
        @(negedge clk); activate = '0;
        check("stop_motor_dn", 32'(motor_dn), 0);
        check("stop_busy",     32'(busy), 0);
        @(negedge clk); activate = 2'b01;
        @(negedge clk); activate = '0;
        check("pause_busy", 32'(busy), 32'b01);
        gap = 0;
        while (motor_up[0] == 1'b0 && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        check("reverse_gap", 32'(gap), 3);
        repeat (2) @(negedge clk); up_limit = 2'b01;
        @(negedge clk);
        check("reverse_opened", 32'(motor_up), 0);

        // Time-out on ch1
        up_limit[1] = 1'b1;
        @(negedge clk); activate = 2'b10;
        @(negedge clk); activate = '0; up_limit[1] = 1'b0;
        cnt = 0;
        while (motor_dn[1] && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_len",   32'(cnt), 20);
        check("timeout_fault", 32'(fault), 32'b10);
        check("timeout_motor", 32'(motor_dn | motor_up), 0);
        activate = 2'b10;
        @(negedge clk); activate = '0;
        check("fault_ignores_act", 32'(fault), 32'b10);
        check("fault_not_busy",    32'(busy), 0);
        fault_clr = 2'b10;
        @(negedge clk); fault_clr = '0;
        check("fault_cleared", 32'(fault), 0);

        // Level hold: one action only
        activate = 2'b01;
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) up_limit[0] = 1'b0;
            if (i == 5) dn_limit[0] = 1'b1;
            if (motor_dn[0]) hi++;
        end
        activate = '0;
        check("hold_once",       32'(hi), 6);
        check("hold_no_restart", 32'(motor_dn | motor_up), 0);

`ifdef MOTOR_OBSTRUCT_EN
        // Obstruction reversal, then limit taking priority over obstruct
        dn_limit = '0; up_limit = 2'b01;
        @(negedge clk); activate = 2'b01;
        @(negedge clk); activate = '0; up_limit = '0;
        repeat (2) @(negedge clk); obstruct = 2'b01;
        @(negedge clk); obstruct = '0;
        gap = 0;
        while (motor_up[0] == 1'b0 && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        check("obstruct_gap", 32'(gap), 3);
        repeat (2) @(negedge clk); up_limit = 2'b01;
        @(negedge clk);
        check("obstruct_opened", 32'(motor_up), 0);
        activate = 2'b01;
        @(negedge clk); activate = '0; up_limit = '0;
        repeat (2) @(negedge clk); dn_limit = 2'b01; obstruct = 2'b01;
        @(negedge clk); obstruct = '0;
        check("limit_beats_obstruct", 32'(busy), 0);
        repeat (4) @(negedge clk);
        check("no_reversal", 32'(motor_up), 0);
`endif

        // Dual limit on ch1 faults
        up_limit = 2'b10; dn_limit = 2'b11;
        @(negedge clk); activate = 2'b10;
        @(negedge clk); activate = '0;
        check("dual_fault",  32'(fault), 32'b10);
        check("dual_motors", 32'(motor_up | motor_dn), 0);
        up_limit = '0; dn_limit = 2'b01; fault_clr = 2'b10;
        @(negedge clk); fault_clr = '0;
        check("dual_cleared", 32'(fault), 0);

        // Asynchronous reset mid-MOV_UP
        activate = 2'b01;
        @(negedge clk); activate = '0; dn_limit = '0;
        check("pre_rst_up", 32'(motor_up), 32'b01);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_up",   32'(motor_up), 0);
        check("async_rst_busy", 32'(busy), 0);
        @(negedge clk); rst = 1'b0;

        // First mid-travel start after reset goes up with no pause
        @(negedge clk); activate = 2'b01;
        @(negedge clk); activate = '0;
        check("post_rst_direct_up", 32'(motor_up), 32'b01);
        repeat (2) @(negedge clk); up_limit = 2'b01;
        @(negedge clk);
        check("final_stop", 32'(motor_up), 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/motor_array.md
# motor_array

- Parametrised N-channel door-motor controller; the next generation of the single-door `motor` block.
- Each channel drives `motor_up`/`motor_dn` from its `activate`, `up_limit` and `dn_limit` inputs, and adds:
  - edge-triggered activation;
  - stop mid-travel;
  - reverse on re-activation through a dead-time pause;
  - travel time-out fault with clear.
- Sits between the push-button/limit-switch interface and the motor drivers; the channels are fully independent.

## Interface
- `N` — 1 — number of door channels.
- `TIMER_W` — 16 — travel timer width.
- `TRAVEL_MAX` — 1000 — max cycles in a moving state before fault; must be < 2^TIMER_W.
- `DEAD_W` — 4 — dead-time counter width.
- `DEAD_CYC` — 4 — cycles with both motors off before a direction reversal; 1..2^DEAD_W-1.
- `clk` — in — 1 — single clock; all logic on posedge.
- `rst` — in — 1 — reset, asynchronous and active-high.
- `activate` — in — N — per-channel button level; only rising edges act.
- `up_limit` — in — N — door fully open.
- `dn_limit` — in — N — door fully closed.
- `obstruct` — in — N — beam-break; present only with `MOTOR_OBSTRUCT_EN`.
- `fault_clr` — in — N — returns a channel from FAULT to REST.
- `motor_up` — out — N — drive open.
- `motor_dn` — out — N — drive close.
- `busy` — out — N — channel in MOV_UP, MOV_DN or PAUSE.
- `fault` — out — N — channel in FAULT.

## Operation
- Per channel:
  - FSM states: REST, MOV_DN, MOV_UP, PAUSE, FAULT.
  - Registers: `act_q` (previous activate), `last_dir` (UP/DN), `next_dir`, travel timer, dead counter.
- Rising edge: `act_edge = activate & ~act_q`.
- Reset values: state REST, `last_dir` = DN, all counters 0, `act_q` 0. All outputs 0.
- REST on `act_edge`:
  - both limits high → FAULT.
  - `up_limit` → MOV_DN.
  - `dn_limit` → MOV_UP.
  - neither (stopped mid-travel) → opposite of `last_dir`, via PAUSE if `last_dir` differs from the new direction.
  - After reset, a mid-travel start goes to MOV_UP directly.
- MOV_DN (`motor_dn`=1), priority high→low:
  1. both limits → FAULT.
  2. `dn_limit` → REST, `last_dir`=DN.
  3. obstruct (macro) → PAUSE, `next_dir`=UP.
  4. `act_edge` → REST (stop), `last_dir`=DN.
  5. timer == TRAVEL_MAX → FAULT.
- MOV_UP: symmetric with `up_limit`. Obstruct is ignored while opening.
- PAUSE:
  - Both motors 0; dead counter counts from 0; at DEAD_CYC-1 → MOV_`next_dir`.
  - `act_edge` during PAUSE → REST, with `last_dir` = `next_dir`'s opposite.
- FAULT:
  - Both motors 0; `fault`=1.
  - `fault_clr` → REST; `last_dir` unchanged.
  - `act_edge` is ignored.
- Travel timer:
  - Clears on entry to any MOV state and increments each MOV cycle.
  - Saturates; never wraps.
- Invariant: `motor_up & motor_dn` is never 1 on any channel. A direct MOV_UP↔MOV_DN transition never occurs.

## Timing
- All outputs are registered and decoded from next-state, so they change on the same edge as the state.
- Latency: input first sampled at posedge n → `motor_*`/`busy`/`fault` update visible after posedge n.
  - Activate: `activate` sampled 1 at posedge n with `act_q`=0 → `motor_dn`=1 after posedge n.
  - Limit: `dn_limit` sampled 1 at posedge m → `motor_dn`=0 after posedge m.
- Holding `activate` high produces one action only; a new action needs a low sample first.
- Reversal gap: exactly DEAD_CYC cycles with both motors 0.
- Asserting `rst` mid-travel drops all motors to 0 asynchronously, without waiting for a clock.

## Configuration
- `MOTOR_OBSTRUCT_EN` defined:
  - `obstruct` port exists.
  - An obstruction in MOV_DN reverses the door through PAUSE to MOV_UP.
- Not defined:
  - No `obstruct` port; the obstruction branch is removed.
  - MOV_DN exits only on limit, edge, time-out or dual-limit fault.

## Test plan
All scenarios use N=2, TRAVEL_MAX=20, DEAD_CYC=3.
- Open-close cycle: ch0 `up_limit`=1, activate pulse → `motor_dn[0]`=1 next edge. `dn_limit` after 5 cycles → `motor_dn`=0, `busy`=0. Activate again → `motor_up`=1 until `up_limit`. Ch1 stays 0.
- Stop and reverse: ch0 activate while closing, with no limits → REST with motors 0. Activate again → exactly 3 cycles both 0, then `motor_up[0]`=1.
- Time-out: ch1 activate from `up_limit`, with `dn_limit` never asserted → `motor_dn[1]` high 20 cycles, then `fault[1]`=1 and motors 0. Activate ignored; `fault_clr[1]` → `fault`=0.
- Level hold: `activate` held high 50 cycles → single transition only; `motor_dn` clears on `dn_limit` and does not restart.
- Obstruction (`MOTOR_OBSTRUCT_EN`): `obstruct` pulse while closing → 3 cycles off, then `motor_up`=1 until `up_limit`. Simultaneous `dn_limit`+`obstruct` → REST with no reversal.
- Reset/dual-limit: `rst` asserted mid-MOV_UP → outputs 0 before the next clock edge. Both limits high with activate → `fault`=1.
